// File: rtl/arith_pkg.sv
// Shared types and elaboration-time helpers for the serial arithmetic blocks.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // True when the operand width splits evenly into whole digits.
    function automatic bit width_ok(input int width, input int digit);
        return (width >= 2) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit combinational full adder; chained to form the per-step digit ripple.
module fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder_n.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock through a full-adder ripple,
// with the carry held in a register between steps.
module serial_adder_n
    import arith_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [1:0]       state_o
);

    localparam int NSTEP = WIDTH / DIGIT;
    localparam int CNT_W = $clog2(NSTEP + 1);

    generate
        if (!width_ok(WIDTH, DIGIT)) begin : g_bad_width
            $error("serial_adder_n: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [DIGIT:0]     chain;
    logic [DIGIT-1:0]   dsum;

    assign chain[0] = carry_q;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        fa_cell u_fa (
            .a_i  (a_q[i]),
            .b_i  (b_q[i]),
            .ci_i (chain[i]),
            .s_o  (dsum[i]),
            .co_o (chain[i+1])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                // Subtraction is A + ~B + ~cin, so invert at load time.
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? ~cin : cin;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                res_d   = (res_q >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
                carry_d = chain[DIGIT];
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(NSTEP - 1)) begin
                    state_d = DONE;
                    sum_d   = res_d;
                    cout_d  = chain[DIGIT];
                    ovf_d   = chain[DIGIT] ^ chain[DIGIT-1];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign sum     = sum_q;
    assign cout    = cout_q;
    assign ovf     = ovf_q;
    assign state_o = state_q;

endmodule
